// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin, packet-aware arbiter sharing one AXI4-Stream uart_tx between
// PORTS requesters. A grant is held until the owner's tlast word is accepted
// or MAX_BURST words have been taken (MAX_BURST = 0 means no limit). Accepted
// words pass through a single registered output stage toward uart_tx.
//
// Optional feature macro: UART_ARB_HEADER_EN
//   When defined, every grant first emits one header word HEADER_BASE + grant
//   (truncated to DATA_WIDTH) before the owner's payload.
//
// Ports:
//   clk                 in   clock
//   rst                 in   asynchronous, active-high reset
//   input_axis_tdata    in   PORTS*DATA_WIDTH, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   input_axis_tvalid   in   PORTS, per-port valid
//   input_axis_tlast    in   PORTS, per-port end of packet
//   input_axis_tready   out  PORTS, one-hot (granted port) or zero
//   output_axis_tdata   out  DATA_WIDTH, to uart_tx
//   output_axis_tvalid  out  1, to uart_tx
//   output_axis_tready  in   1, from uart_tx
//   grant               out  $clog2(PORTS), current or most recent owner
//   busy                out  1, grant held or output register full
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         PORTS       = 4,
  parameter int         DATA_WIDTH  = 8,
  parameter int         MAX_BURST   = 0,
  parameter logic [7:0] HEADER_BASE = 8'hA0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*DATA_WIDTH-1:0]   input_axis_tdata,
  input  logic [PORTS-1:0]              input_axis_tvalid,
  input  logic [PORTS-1:0]              input_axis_tlast,
  output logic [PORTS-1:0]              input_axis_tready,
  output logic [DATA_WIDTH-1:0]         output_axis_tdata,
  output logic                          output_axis_tvalid,
  input  logic                          output_axis_tready,
  output logic [$clog2(PORTS)-1:0]      grant,
  output logic                          busy
);

  localparam int GW = $clog2(PORTS);
  localparam int CW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam bit LIMITED = (MAX_BURST > 0);
  // Counter saturates at the burst limit; with no limit it simply parks at all-ones.
  localparam logic [CW-1:0] BURST_CAP = LIMITED ? CW'(MAX_BURST) : {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
`ifdef UART_ARB_HEADER_EN
    , S_HDR  = 2'd2
`endif
  } state_e;

`ifdef UART_ARB_HEADER_EN
  localparam state_e S_FIRST = S_HDR;
`else
  localparam state_e S_FIRST = S_ACTIVE;
`endif

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [GW-1:0]         last_q, last_d;
  logic [CW-1:0]         burst_q, burst_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [GW-1:0]         pick;
  logic [GW-1:0]         scan_idx;
  logic                  slot_free;
  logic                  load;
  logic                  hdr_load;
  logic [DATA_WIDTH-1:0] hdr_word;
  logic [DATA_WIDTH-1:0] load_data;

  // The output register can take a word when empty or when it drains this cycle.
  assign slot_free = ~out_valid_q | output_axis_tready;
  assign hdr_word  = DATA_WIDTH'(HEADER_BASE) + DATA_WIDTH'(grant_q);
  assign load_data = hdr_load ? hdr_word
                              : input_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];

  // Round-robin pick: first requester at or after last_q+1, wrapping.
  always_comb begin
    pick     = last_q;
    scan_idx = last_q;
    // Walk from the farthest candidate back toward last_q+1 so the nearest
    // requester is written last and wins; k = PORTS is last_q itself.
    for (int k = PORTS; k >= 1; k--) begin
      scan_idx = GW'((int'(last_q) + k) % PORTS);
      if (input_axis_tvalid[scan_idx]) pick = scan_idx;
    end
  end

  // Next-state and handshake logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    burst_d           = burst_q;
    load              = 1'b0;
    hdr_load          = 1'b0;
    input_axis_tready = '0;

    unique case (state_q)
      S_IDLE: begin
        if (|input_axis_tvalid) begin
          grant_d = pick;
          burst_d = '0;
          state_d = S_FIRST;
        end
      end
`ifdef UART_ARB_HEADER_EN
      S_HDR: begin
        if (slot_free) begin
          load     = 1'b1;
          hdr_load = 1'b1;
          state_d  = S_ACTIVE;
        end
      end
`endif
      S_ACTIVE: begin
        input_axis_tready[grant_q] = slot_free;
        if (slot_free && input_axis_tvalid[grant_q]) begin
          load = 1'b1;
          if (burst_q != BURST_CAP) burst_d = burst_q + 1'b1;
          // Release on tlast or when this word brings the burst to its limit.
          if (input_axis_tlast[grant_q] || (LIMITED && burst_d == BURST_CAP)) begin
            last_d  = grant_q;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output register: load wins; otherwise a downstream ready empties it.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = load_data;
    end else if (output_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      last_q      <= GW'(PORTS - 1);
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign output_axis_tvalid = out_valid_q;
  assign output_axis_tdata  = out_data_q;
  assign grant              = grant_q;
  assign busy               = (state_q != S_IDLE) | out_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Drives per-port packet queues into uart_tx_arbiter and compares every cycle
// against a transaction-level reference: an owner index (-1 when free), a
// word count per grant, and a one-entry output slot. Directed scenarios then
// compare the observed output stream and grant order with fixed expectations.
// Builds with or without UART_ARB_HEADER_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int         P  = 4;
  localparam int         DW = 8;
  localparam int         MB = 2;
  localparam logic [7:0] HB = 8'hA0;
`ifdef UART_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [P*DW-1:0] in_data  = '0;
  logic [P-1:0]  in_valid = '0;
  logic [P-1:0]  in_last  = '0;
  logic [P-1:0]  in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    grant;
  logic          busy;

  uart_tx_arbiter #(
    .PORTS(P), .DATA_WIDTH(DW), .MAX_BURST(MB), .HEADER_BASE(HB)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tlast   (in_last),
    .input_axis_tready  (in_ready),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .grant              (grant),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus state
  logic [8:0]   src_q [P][$];   // {tlast, data} per port
  logic [8:0]   sent_q[$];      // words offered in the current scenario
  logic [P-1:0] en_mask = '1;
  int           gap_pct = 0;
  int           ds_mode = 0;    // 0 always ready, 1 random, 2 one cycle in ten
  int           ds_cnt  = 0;
  int           pushed  = 0;

  // Reference model
  int         m_owner, m_last, m_grant, m_cnt, m_hdr_words;
  bit         m_hdr, m_full;
  logic [7:0] m_data;

  // Observations
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         acc_port_q[$];
  logic       s_busy;
  logic [1:0] s_grant;

  function automatic bit bit_at(input logic [P-1:0] v, input int i);
    logic [P-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < P; p++) if (src_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send(input int p, input logic [7:0] d, input bit l);
    src_q[p].push_back({l, d});
    sent_q.push_back({l, d});
    pushed++;
  endtask

  task automatic reset_model_and_logs();
    m_owner = -1; m_last = P - 1; m_grant = 0; m_cnt = 0;
    m_hdr = 1'b0; m_full = 1'b0; m_data = '0; m_hdr_words = 0;
    for (int p = 0; p < P; p++) src_q[p].delete();
    sent_q.delete(); obs_q.delete(); exp_q.delete(); acc_port_q.delete();
    pushed = 0; ds_cnt = 0; en_mask = '1; gap_pct = 0; ds_mode = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    reset_model_and_logs();
  endtask

  // One clock: drive at negedge, compare at negedge+1, advance the model.
  task automatic step();
    logic [P-1:0] v, l, exp_rdy;
    logic [8:0]   w;
    logic [7:0]   nd;
    bit           slot_free, load;
    int           pick;
    v = '0; l = '0;
    for (int p = 0; p < P; p++) begin
      in_data[p*DW +: DW] = '0;
      if (bit_at(en_mask, p) && src_q[p].size() > 0 &&
          int'($urandom_range(99)) >= gap_pct) begin
        w = src_q[p][0];
        v |= P'(1) << p;
        if (w[8]) l |= P'(1) << p;
        in_data[p*DW +: DW] = w[7:0];
      end
    end
    in_valid = v; in_last = l;
    case (ds_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(1));
      default: begin out_ready = (ds_cnt == 9); ds_cnt = (ds_cnt + 1) % 10; end
    endcase
    #1;
    slot_free = !m_full || out_ready;
    exp_rdy   = '0;
    if (m_owner >= 0 && !m_hdr && slot_free) exp_rdy = P'(1) << m_owner;
    check("tready", 32'(in_ready), 32'(exp_rdy));
    check("ovalid", 32'(out_valid), 32'(m_full));
    if (m_full) check("odata", 32'(out_data), 32'(m_data));
    check("grant", 32'(grant), 32'(m_grant));
    check("busy", 32'(busy), 32'(m_owner >= 0 || m_full));
    s_busy = busy; s_grant = grant;
    if (out_valid && out_ready) obs_q.push_back(out_data);
    for (int p = 0; p < P; p++)
      if (bit_at(in_ready & in_valid, p)) acc_port_q.push_back(p);

    load = 1'b0; nd = m_data;
    if (m_owner < 0) begin
      if (in_valid != '0) begin
        pick = -1;
        for (int k = 1; k <= P; k++)
          if (pick < 0 && bit_at(in_valid, (m_last + k) % P)) pick = (m_last + k) % P;
        m_owner = pick; m_grant = pick; m_cnt = 0; m_hdr = HDR_EN;
      end
    end else if (m_hdr) begin
      if (slot_free) begin
        load = 1'b1; nd = 8'(HB + m_owner); m_hdr = 1'b0; m_hdr_words++;
      end
    end else if (exp_rdy != '0 && bit_at(in_valid, m_owner)) begin
      w = src_q[m_owner].pop_front();
      load = 1'b1; nd = w[7:0]; m_cnt++;
      if (w[8] || (MB != 0 && m_cnt == MB)) begin m_last = m_owner; m_owner = -1; end
    end
    if (load) begin m_full = 1'b1; m_data = nd; end
    else if (out_ready) m_full = 1'b0;

    @(posedge clk); @(negedge clk);
  endtask

  task automatic run_until_obs(input int n, input int budget, input string tag);
    int c = 0;
    while (obs_q.size() < n && c < budget) begin step(); c++; end
    if (obs_q.size() < n) check({tag, "_timeout"}, 32'(obs_q.size()), 32'(n));
  endtask

  // Expected stream for one requester: words grouped into grants of up to MB
  // words (or ending at tlast), each grant optionally prefixed by a header.
  task automatic build_single(input int port);
    int cnt = 0;
    bit start = 1'b1;
    exp_q.delete();
    foreach (sent_q[i]) begin
      if (start && HDR_EN) exp_q.push_back(8'(HB + port));
      start = 1'b0;
      exp_q.push_back(sent_q[i][7:0]);
      cnt++;
      if (sent_q[i][8] || cnt == MB) begin start = 1'b1; cnt = 0; end
    end
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < obs_q.size())
        check($sformatf("%s_w%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [8:0] unused_w;
    int c;
    unused_w = '0;

    // Reset values
    do_reset();
    #1;
    check("rst_tready", 32'(in_ready), 32'h0);
    check("rst_ovalid", 32'(out_valid), 32'h0);
    check("rst_odata", 32'(out_data), 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);

    // Single requester on port 2
    send(2, 8'h11, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h33, 1'b1);
    build_single(2);
    run_until_obs(exp_q.size(), 100, "single");
    cmp_stream("single");
    check("single_busy_at_last", 32'(s_busy), 32'h1);
    step();
    check("single_busy_fall", 32'(s_busy), 32'h0);
    check("single_grant", 32'(s_grant), 32'h2);

    // Round robin with every port holding 1-word packets
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < P; p++) send(p, 8'(8'h40 + p * 16 + k), 1'b1);
    run_until_obs(HDR_EN ? 16 : 8, 200, "rr");
    check("rr_count", 32'(acc_port_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < acc_port_q.size()) check($sformatf("rr_order%0d", i), 32'(acc_port_q[i]), 32'(i % P));
    check("rr_words", 32'(obs_q.size()), 32'(HDR_EN ? 16 : 8));

    // Backpressure: downstream ready one cycle in ten
    obs_q.delete(); sent_q.delete();
    ds_mode = 2; ds_cnt = 0;
    for (int i = 0; i < 5; i++) send(3, 8'(8'hC0 + i), i == 4);
    build_single(3);
    run_until_obs(exp_q.size(), 400, "bp");
    cmp_stream("bp");

    // Burst limit: port 0 streams without tlast while port 1 waits
    do_reset();
    for (int i = 0; i < 5; i++) send(0, 8'(8'h50 + i), 1'b0);
    send(1, 8'h91, 1'b0); send(1, 8'h92, 1'b1);
`ifdef UART_ARB_HEADER_EN
    exp_q = '{8'hA0, 8'h50, 8'h51, 8'hA1, 8'h91, 8'h92, 8'hA0, 8'h52, 8'h53, 8'hA0, 8'h54};
`else
    exp_q = '{8'h50, 8'h51, 8'h91, 8'h92, 8'h52, 8'h53, 8'h54};
`endif
    run_until_obs(exp_q.size(), 200, "burst");
    cmp_stream("burst");

    // Mid-packet stall: port 1 keeps the grant while port 3 waits
    do_reset();
    send(1, 8'h61, 1'b0);
    run_until_obs(HDR_EN ? 2 : 1, 50, "stall_first");
    en_mask = 4'b1101;
    send(1, 8'h62, 1'b1);
    send(3, 8'h71, 1'b1);
    for (int i = 0; i < 20; i++) step();
    check("stall_grant_held", 32'(s_grant), 32'h1);
    check("stall_no_p3", 32'(obs_q.size()), 32'(HDR_EN ? 2 : 1));
    en_mask = '1;
`ifdef UART_ARB_HEADER_EN
    exp_q = '{8'hA1, 8'h61, 8'h62, 8'hA3, 8'h71};
`else
    exp_q = '{8'h61, 8'h62, 8'h71};
`endif
    run_until_obs(exp_q.size(), 100, "stall");
    cmp_stream("stall");

    // Asynchronous reset while word 2 of a packet sits in the output register
    obs_q.delete();
    send(2, 8'h81, 1'b0); send(2, 8'h82, 1'b0); send(2, 8'h83, 1'b1);
    run_until_obs(HDR_EN ? 2 : 1, 50, "areset_pre");
    #1;
    check("areset_pre_valid", 32'(out_valid), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("areset_ovalid", 32'(out_valid), 32'h0);
    check("areset_odata", 32'(out_data), 32'h0);
    check("areset_tready", 32'(in_ready), 32'h0);
    check("areset_busy", 32'(busy), 32'h0);
    check("areset_grant", 32'(grant), 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    reset_model_and_logs();
    send(1, 8'h31, 1'b1); send(2, 8'h32, 1'b1); send(3, 8'h33, 1'b1); send(0, 8'h30, 1'b1);
    run_until_obs(HDR_EN ? 8 : 4, 100, "areset_post");
    check("areset_count", 32'(acc_port_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < acc_port_q.size()) check($sformatf("areset_order%0d", i), 32'(acc_port_q[i]), 32'(i));

    // Randomized traffic: random packets, gaps and downstream ready
    do_reset();
    gap_pct = 25; ds_mode = 1;
    for (int p = 0; p < P; p++) begin
      int np;
      np = $urandom_range(6, 3);
      for (int k = 0; k < np; k++) begin
        int len;
        len = $urandom_range(4, 1);
        for (int j = 0; j < len; j++) send(p, 8'($urandom), j == len - 1);
      end
    end
    c = 0;
    while (c < 6000 && !(all_empty() && !m_full && m_owner < 0)) begin step(); c++; end
    if (c >= 6000) check("rand_drain_timeout", 32'(c), 32'd0);
    step();
    check("rand_words", 32'(obs_q.size()), 32'(pushed + m_hdr_words));
    check("rand_idle", 32'(s_busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-aware arbiter that shares one AXI4-Stream `uart_tx` transmitter between `PORTS` independent requesters. It sits directly upstream of `uart_tx`. It grants one requester at a time and holds the grant until that requester's `tlast` word, or until a burst limit is reached. Its single registered output stage drives the transmitter's input stream.

## Interface
Parameters:
- `PORTS`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 8: word width; must match `uart_tx`.
- `MAX_BURST`, default 0: maximum words per grant. 0 means unlimited (release only on `tlast`).
- `HEADER_BASE`, default 8'hA0: base value of the source-ID header word. Used only with `UART_ARB_HEADER_EN`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous and active-high.
- `input_axis_tdata`  in  `PORTS*DATA_WIDTH`: requester data. Port i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `input_axis_tvalid`  in  `PORTS`: per-port valid.
- `input_axis_tlast`  in  `PORTS`: per-port end of packet.
- `input_axis_tready`  out  `PORTS`: per-port ready. It is one-hot or zero.
- `output_axis_tdata`  out  `DATA_WIDTH`: to `uart_tx input_axis_tdata`.
- `output_axis_tvalid`  out  1: to `uart_tx input_axis_tvalid`.
- `output_axis_tready`  in  1: from `uart_tx input_axis_tready`.
- `grant`  out  `$clog2(PORTS)`: index of the current or most recent owner.
- `busy`  out  1: a grant is held or the output register is full.

## Operation
- State machine: IDLE, HDR (only with macro), ACTIVE.
- IDLE:
  - If any `tvalid` is high, select the first asserted port scanning upward from `last+1`, wrapping modulo `PORTS`.
  - Register `grant`, clear the burst counter, and go to HDR or ACTIVE.
  - While in IDLE, `input_axis_tready` is all zero.
- HDR:
  - When the output register is empty or draining, load it with `HEADER_BASE + grant`, truncated to `DATA_WIDTH`.
  - Then go to ACTIVE.
- ACTIVE:
  - `input_axis_tready[grant] = ~output_axis_tvalid | output_axis_tready`; all other bits are 0.
  - On each accepted word, load the output register and increment the burst counter.
  - Release the grant on an accepted word that has `tlast`, or when the burst counter reaches `MAX_BURST` (if nonzero). On release, `last <= grant` and the next state is IDLE.
- Output register:
  - `output_axis_tvalid` is set on load.
  - It is cleared when `output_axis_tready` is high and no new load happens that cycle.
  - Data is held stable while `valid & ~ready`.
- A granted port that drops `tvalid` mid-packet keeps the grant indefinitely. There is no timeout.
- Burst counter width is `$clog2(MAX_BURST+1)`, minimum 1. It saturates at the limit and never wraps.
- `busy = (state != IDLE) | output_axis_tvalid`.

## Timing
- Reset values:
  - `input_axis_tready` = 0, `output_axis_tvalid` = 0, `output_axis_tdata` = 0.
  - `grant` = 0, `busy` = 0, `last` = `PORTS-1`, so port 0 wins first.
- Arbitration takes 1 cycle:
  - A request seen in IDLE on cycle N gives `grant` valid at N+1.
  - First-word ready is at N+1 without the header, or N+2 with the header.
- Input to output latency is 1 cycle: an accepted word appears on `output_axis_tdata` in the next cycle.
- Throughput is 1 word/cycle when downstream is ready. In practice it is limited by `uart_tx`, which asserts ready only between characters.
- Between packets there is 1 IDLE cycle of ready=0 on all ports. The output register may still drain during that cycle.
- Simultaneous requests: the round-robin order decides; no port gets two consecutive grants while another port is waiting.
- A `tvalid` deassertion on the granted port in the same cycle as release has no effect.
- Reset asserted mid-packet:
  - All outputs return to reset values immediately (asynchronously), and any word in the register is discarded.
  - A character already shifting in `uart_tx` is not affected by this block.

## Configuration
- `UART_ARB_HEADER_EN`:
  - Defined: the HDR state exists, and each grant emits one header word `HEADER_BASE + grant` before the packet's payload.
  - Undefined: there is no HDR state, and IDLE goes directly to ACTIVE. The output stream is the concatenated raw packets.

## Test plan
- Single requester: reset, then port 2 sends 3 words 8'h11/8'h22/8'h33 with `tlast` on the third, and downstream is ready.
  - Output is 11, 22, 33 (prefixed by A2 if the macro is defined).
  - `grant`=2, and `busy` falls 1 cycle after the last transfer.
- Round robin: all 4 ports hold `tvalid` with 1-word packets.
  - Grant order after reset is 0, 1, 2, 3, 0.
  - No word is lost or duplicated.
- Backpressure: `output_axis_tready` toggles 1 high cycle every 10 cycles (a `uart_tx` model with `prescale`=1) during a 5-word packet.
  - Output data is held stable while ready=0.
  - Exactly 5 transfers occur, in order.
- Burst limit: `MAX_BURST`=2, port 0 sends 5 words without `tlast`, and port 1 is requesting.
  - Sequence is p0 w0, w1, then p1's packet, then p0 w2, w3, then p0 w4.
- Mid-packet stall: granted port 1 drops `tvalid` for 20 cycles while port 3 requests.
  - Grant stays 1 and no port-3 data appears.
  - Port 1 resumes and completes, then port 3 is granted.
- Async reset: assert `rst` for 1 cycle between clock edges during word 2 of a packet.
  - `output_axis_tvalid` goes 0 immediately.
  - After release, the first grant goes to port 0.
